// File: rtl/tenthirty_pkg.sv
// Shared definitions for the ten-and-a-half card game blocks: arbiter
// state encoding, legal card range, default deck/hand sizes, requester ids.
package tenthirty_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } arb_state_t;

    localparam logic [3:0] CARD_MIN = 4'd1;
    localparam logic [3:0] CARD_MAX = 4'd13;

    localparam int DEF_DECK_SIZE = 52;
    localparam int DEF_MAX_CARDS = 5;

    localparam int PLAYER = 0;
    localparam int DEALER = 1;

    // A deck value is deliverable only inside the 1..13 range.
    function automatic logic is_legal_card(input logic [3:0] v);
        return (v >= CARD_MIN) && (v <= CARD_MAX);
    endfunction

endpackage

// File: rtl/card_draw_arbiter_if.sv
// Bundle between the game controllers / deck LUT and the draw arbiter.
// master = game + LUT side, slave = arbiter.
interface card_draw_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int TAG_W = 1
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] hand_clr;
    logic             shuffle;
    logic             deck_pip;
    logic [3:0]       deck_number;
    logic             card_valid;
    logic [3:0]       card_value;
    logic [TAG_W-1:0] card_tag;
    logic             busy;
    logic [5:0]       cards_left;
    logic             deck_empty;
    logic [N_REQ-1:0] hand_full;
    logic             err_timeout;
    logic             err_bad_card;

    modport master (
        output req, hand_clr, shuffle, deck_number,
        input  deck_pip, card_valid, card_value, card_tag, busy,
               cards_left, deck_empty, hand_full, err_timeout, err_bad_card
    );

    modport slave (
        input  req, hand_clr, shuffle, deck_number,
        output deck_pip, card_valid, card_value, card_tag, busy,
               cards_left, deck_empty, hand_full, err_timeout, err_bad_card
    );
endinterface

// File: rtl/card_draw_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible index at or after
// i_rr_ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int TAG_W = 1
) (
    input  logic [N_REQ-1:0] i_eligible,
    input  logic [TAG_W-1:0] i_rr_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [TAG_W-1:0] o_owner,
    output logic             o_any
);

    // Scan N_REQ positions starting at the pointer; the first hit wins.
    always_comb begin
        int w_idx;
        o_grant = '0;
        o_owner = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(i_rr_ptr) + k) % N_REQ;
            if (!o_any && i_eligible[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_owner        = TAG_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/card_draw_arbiter.sv
// Shares the deck LUT between the player and dealer controllers: latches
// draw requests, arbitrates round-robin, runs the pip/number handshake and
// returns the card tagged with its owner. Also keeps deck and hand counts.
module card_draw_arbiter
    import tenthirty_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int TAG_W     = 1,
    parameter int DECK_SIZE = DEF_DECK_SIZE,
    parameter int MAX_CARDS = DEF_MAX_CARDS,
    parameter int TIMEOUT   = 16
) (
    input logic               clk,
    input logic               rst,
    card_draw_arbiter_if.slave bus
);

    localparam int HC_W  = $clog2(MAX_CARDS + 1);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t                  r_state, w_next;
    logic [N_REQ-1:0]            r_pending;
    logic [N_REQ-1:0][HC_W-1:0]  r_hand_cnt;
    logic [TAG_W-1:0]            r_rr_ptr;
    logic [TAG_W-1:0]            r_owner;
    logic [TMR_W-1:0]            r_timer;
    logic                        r_shuffle_pend;
    logic [5:0]                  r_cards_left;
    logic [3:0]                  r_card;
    logic                        r_err_tmo;
    logic                        r_err_bad;

    logic [N_REQ-1:0]            w_hand_full;
    logic                        w_deck_empty;
    logic [N_REQ-1:0]            w_eligible;
    logic [N_REQ-1:0]            w_grant;
    logic [TAG_W-1:0]            w_owner;
    logic                        w_any;
    logic                        w_do_shuffle;
    logic                        w_card_ok;
    logic                        w_card_bad;
    logic                        w_tmo_hit;
    logic                        w_err_exit;
    logic                        w_release;
    logic [TAG_W-1:0]            w_next_ptr;

    // Status decode and eligibility; a req arriving this cycle can win
    // immediately, which gives the req -> pip one-cycle latency.
    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            w_hand_full[i] = (r_hand_cnt[i] == HC_W'(MAX_CARDS));
        w_deck_empty = (r_cards_left == '0);
        w_eligible   = (r_pending | bus.req) & ~w_hand_full & {N_REQ{~w_deck_empty}};
        w_do_shuffle = (r_state == S_IDLE) && (r_shuffle_pend || bus.shuffle);
        w_card_ok    = is_legal_card(bus.deck_number);
        w_card_bad   = (bus.deck_number > CARD_MAX);
        w_tmo_hit    = (r_timer == TMR_W'(TIMEOUT - 1));
        w_err_exit   = (r_state == S_WAIT) && !w_card_ok && (w_card_bad || w_tmo_hit);
        w_release    = (r_state == S_DELIVER) || w_err_exit;
        w_next_ptr   = (r_owner == TAG_W'(N_REQ - 1)) ? '0 : r_owner + TAG_W'(1);
    end

    rr_pick #(.N_REQ(N_REQ), .TAG_W(TAG_W)) u_pick (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_rr_ptr),
        .o_grant    (w_grant),
        .o_owner    (w_owner),
        .o_any      (w_any)
    );

    // Next-state logic; a shuffle in IDLE takes the cycle instead of a grant.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (!w_do_shuffle && w_any) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_WAIT;
            S_WAIT: begin
                if (w_card_ok)       w_next = S_DELIVER;
                else if (w_err_exit) w_next = S_IDLE;
            end
            S_DELIVER: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Draw datapath: owner latch, WAIT timer, card latch, error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner   <= '0;
            r_timer   <= '0;
            r_card    <= '0;
            r_err_tmo <= 1'b0;
            r_err_bad <= 1'b0;
        end else begin
            if (r_state == S_IDLE && !w_do_shuffle && w_any)
                r_owner <= w_owner;
            if (r_state == S_ISSUE)
                r_timer <= '0;
            else if (r_state == S_WAIT && bus.deck_number == 4'd0 && !w_tmo_hit)
                r_timer <= r_timer + TMR_W'(1);
            if (r_state == S_WAIT && w_card_ok)
                r_card <= bus.deck_number;
            r_err_tmo <= w_err_exit && !w_card_bad;
            r_err_bad <= w_err_exit && w_card_bad;
        end
    end

    // Per-requester pending bits and hand counts; new req and hand_clr win.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_hand_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req[i])
                    r_pending[i] <= 1'b1;
                else if (w_release && r_owner == TAG_W'(i))
                    r_pending[i] <= 1'b0;
                if (bus.hand_clr[i])
                    r_hand_cnt[i] <= '0;
                else if (r_state == S_DELIVER && r_owner == TAG_W'(i))
                    r_hand_cnt[i] <= r_hand_cnt[i] + HC_W'(1);
            end
        end
    end

    // Deck count, deferred shuffle and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cards_left   <= 6'(DECK_SIZE);
            r_shuffle_pend <= 1'b0;
            r_rr_ptr       <= '0;
        end else begin
            if (w_do_shuffle)
                r_cards_left <= 6'(DECK_SIZE);
            else if (r_state == S_DELIVER)
                r_cards_left <= r_cards_left - 6'd1;
            if (w_do_shuffle)
                r_shuffle_pend <= 1'b0;
            else if (bus.shuffle)
                r_shuffle_pend <= 1'b1;
            if (w_release)
                r_rr_ptr <= w_next_ptr;
        end
    end

    assign bus.deck_pip     = (r_state == S_ISSUE);
    assign bus.card_valid   = (r_state == S_DELIVER);
    assign bus.card_value   = r_card;
    assign bus.card_tag     = r_owner;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.cards_left   = r_cards_left;
    assign bus.deck_empty   = w_deck_empty;
    assign bus.hand_full    = w_hand_full;
    assign bus.err_timeout  = r_err_tmo;
    assign bus.err_bad_card = r_err_bad;

endmodule

// File: tb/tb_card_draw_arbiter.sv
// Directed bench for card_draw_arbiter: a table of draw vectors plus
// hand-written sequences for latency, deck drain, shuffle and reset cases.
module tb_card_draw_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    card_draw_arbiter_if #(.N_REQ(2), .TAG_W(1)) bus ();

    card_draw_arbiter #(
        .N_REQ(2), .TAG_W(1), .DECK_SIZE(52), .MAX_CARDS(5), .TIMEOUT(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] req;
        logic [1:0] hclr;
        logic       shuf;
        logic [3:0] lut;
        int         cyc;
        int         e_pip;
        int         e_valid;
        logic [3:0] e_val;
        logic       e_tag0;
        logic       e_tag;
        int         e_tmo;
        int         e_bad;
        int         e_cl;
        logic [1:0] e_hf;
    } vec_t;

    vec_t vt[12];

    int checks = 0;
    int errors = 0;
    int n_pip, n_valid, n_tmo, n_bad;
    logic [3:0] last_val;
    logic       first_tag, last_tag;
    logic [3:0] lut_val = 4'd0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_cnt();
        n_pip = 0; n_valid = 0; n_tmo = 0; n_bad = 0;
        last_val = 4'd0; first_tag = 1'b0; last_tag = 1'b0;
    endtask

    // One clock; sample just after the edge and play the deck LUT role.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.deck_pip) begin
            n_pip++;
            bus.deck_number = lut_val;
        end
        if (bus.card_valid) begin
            if (n_valid == 0) first_tag = bus.card_tag;
            n_valid++;
            last_val = bus.card_value;
            last_tag = bus.card_tag;
        end
        if (bus.err_timeout)  n_tmo++;
        if (bus.err_bad_card) n_bad++;
    endtask

    initial begin
        bus.req = '0; bus.hand_clr = '0; bus.shuffle = 1'b0; bus.deck_number = 4'd0;
        clr_cnt();

        //            req    hclr  sh  lut    cyc pip val v      t0    t     tmo bad cl  hf
        vt[0]  = '{2'b10, 2'b00, 0, 4'd3,  6,  1,  1, 4'd3,  1'b1, 1'b1, 0, 0, 50, 2'b00};
        vt[1]  = '{2'b11, 2'b00, 0, 4'd9,  10, 2,  2, 4'd9,  1'b0, 1'b1, 0, 0, 48, 2'b00};
        vt[2]  = '{2'b01, 2'b00, 0, 4'd2,  6,  1,  1, 4'd2,  1'b0, 1'b0, 0, 0, 47, 2'b00};
        vt[3]  = '{2'b01, 2'b00, 0, 4'd13, 6,  1,  1, 4'd13, 1'b0, 1'b0, 0, 0, 46, 2'b00};
        vt[4]  = '{2'b01, 2'b00, 0, 4'd1,  6,  1,  1, 4'd1,  1'b0, 1'b0, 0, 0, 45, 2'b01};
        vt[5]  = '{2'b01, 2'b00, 0, 4'd4,  8,  0,  0, 4'd0,  1'b0, 1'b0, 0, 0, 45, 2'b01};
        vt[6]  = '{2'b00, 2'b01, 0, 4'd4,  8,  1,  1, 4'd4,  1'b0, 1'b0, 0, 0, 44, 2'b00};
        vt[7]  = '{2'b01, 2'b00, 0, 4'd0,  24, 1,  0, 4'd0,  1'b0, 1'b0, 1, 0, 44, 2'b00};
        vt[8]  = '{2'b10, 2'b00, 0, 4'd14, 6,  1,  0, 4'd0,  1'b0, 1'b0, 0, 1, 44, 2'b00};
        vt[9]  = '{2'b10, 2'b00, 0, 4'd15, 6,  1,  0, 4'd0,  1'b0, 1'b0, 0, 1, 44, 2'b00};
        vt[10] = '{2'b01, 2'b00, 0, 4'd8,  8,  0,  0, 4'd0,  1'b0, 1'b0, 0, 0, 0,  2'b00};
        vt[11] = '{2'b00, 2'b00, 1, 4'd8,  8,  1,  1, 4'd8,  1'b0, 1'b0, 0, 0, 51, 2'b00};

        // Reset state.
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy",       bus.busy, 0);
        chk("rst_cards_left", bus.cards_left, 52);
        chk("rst_deck_empty", bus.deck_empty, 0);
        chk("rst_hand_full",  bus.hand_full, 0);
        chk("rst_card_valid", bus.card_valid, 0);
        chk("rst_deck_pip",   bus.deck_pip, 0);
        chk("rst_card_value", bus.card_value, 0);
        chk("rst_card_tag",   bus.card_tag, 0);
        chk("rst_errs",       {bus.err_timeout, bus.err_bad_card}, 0);
        repeat (7) tick();

        // First player draw: pip one cycle after req, card two cycles later.
        clr_cnt();
        lut_val = 4'd7;
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        chk("first_pip", bus.deck_pip, 1);
        tick();
        chk("first_no_valid_yet", bus.card_valid, 0);
        tick();
        chk("first_valid", bus.card_valid, 1);
        chk("first_value", bus.card_value, 7);
        chk("first_tag",   bus.card_tag, 0);
        tick(); tick();
        chk("first_cards_left", bus.cards_left, 51);
        chk("first_busy_done",  bus.busy, 0);

        // Table vectors; the deck is drained just before vector 10.
        for (int i = 0; i < 12; i++) begin
            if (i == 10) begin
                clr_cnt();
                for (int k = 0; k < 44; k++) begin
                    lut_val = 4'd6;
                    bus.req = 2'b01; bus.hand_clr = 2'b01;
                    tick();
                    bus.req = 2'b00; bus.hand_clr = 2'b00;
                    repeat (5) tick();
                end
                chk("drain_valid_cnt", n_valid, 44);
                chk("drain_cards_left", bus.cards_left, 0);
                chk("drain_deck_empty", bus.deck_empty, 1);
            end
            clr_cnt();
            lut_val      = vt[i].lut;
            bus.req      = vt[i].req;
            bus.hand_clr = vt[i].hclr;
            bus.shuffle  = vt[i].shuf;
            tick();
            bus.req = 2'b00; bus.hand_clr = 2'b00; bus.shuffle = 1'b0;
            repeat (vt[i].cyc - 1) tick();
            chk($sformatf("v%0d_pip", i),   n_pip,   vt[i].e_pip);
            chk($sformatf("v%0d_valid", i), n_valid, vt[i].e_valid);
            chk($sformatf("v%0d_tmo", i),   n_tmo,   vt[i].e_tmo);
            chk($sformatf("v%0d_bad", i),   n_bad,   vt[i].e_bad);
            chk($sformatf("v%0d_cards_left", i), bus.cards_left, vt[i].e_cl);
            chk($sformatf("v%0d_deck_empty", i), bus.deck_empty, int'(vt[i].e_cl == 0));
            chk($sformatf("v%0d_hand_full", i),  bus.hand_full, vt[i].e_hf);
            chk($sformatf("v%0d_busy", i),       bus.busy, 0);
            if (vt[i].e_valid > 0) begin
                chk($sformatf("v%0d_value", i),     last_val,  vt[i].e_val);
                chk($sformatf("v%0d_first_tag", i), first_tag, vt[i].e_tag0);
                chk($sformatf("v%0d_last_tag", i),  last_tag,  vt[i].e_tag);
            end
        end

        // Shuffle arriving during WAIT is held until the next IDLE.
        clr_cnt();
        lut_val = 4'd0;
        bus.req = 2'b01;
        tick();
        bus.req = 2'b00;
        tick();
        bus.shuffle = 1'b1;
        tick();
        bus.shuffle = 1'b0;
        chk("shwait_busy",       bus.busy, 1);
        chk("shwait_cards_held", bus.cards_left, 51);
        repeat (20) tick();
        chk("shwait_tmo",        n_tmo, 1);
        chk("shwait_valid",      n_valid, 0);
        chk("shwait_cards_left", bus.cards_left, 52);

        // Reset during WAIT drops the draw silently.
        clr_cnt();
        lut_val = 4'd0;
        bus.req = 2'b10;
        tick();
        bus.req = 2'b00;
        tick();
        chk("rstwait_busy_before", bus.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr_cnt();
        chk("rstwait_busy",       bus.busy, 0);
        chk("rstwait_valid",      bus.card_valid, 0);
        chk("rstwait_pip",        bus.deck_pip, 0);
        chk("rstwait_cards_left", bus.cards_left, 52);
        chk("rstwait_hand_full",  bus.hand_full, 0);
        chk("rstwait_errs",       {bus.err_timeout, bus.err_bad_card}, 0);
        repeat (20) tick();
        chk("rstwait_no_pip",   n_pip, 0);
        chk("rstwait_no_valid", n_valid, 0);
        chk("rstwait_no_err",   n_tmo + n_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
